// File: rtl/npu_pkg.sv
// Shared definitions for the NPU configuration path.
// Config word layout, opcodes and loader state encoding.
package npu_pkg;

   localparam int NUM_BUF = 9;
   localparam int DATA_W  = 16;
   localparam int CNT_W   = 10;
   localparam int FIFO_W  = 26;
   localparam int ID_W    = 4;

   localparam int OP_HI = 25;
   localparam int OP_LO = 24;
   localparam int ID_HI = 23;
   localparam int ID_LO = 20;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_HDR    = 2'b01;
   localparam logic [1:0] OP_DATA   = 2'b10;
   localparam logic [1:0] OP_COMMIT = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOAD = 1'b1;

   typedef struct packed {
      logic [OP_HI-OP_LO:0] op;
      logic [ID_W-1:0]      id;
      logic [ID_LO-1:0]     body;
   } cfg_word_t;

endpackage

// File: rtl/npu_cbuf_port_arb.sv
// Single-port arbitration for the circular buffer vector.
// The buffer under load never sees a read while config owns it.
module npu_cbuf_port_arb #(
   parameter int NUM_BUF = 9
) (
   input  logic [NUM_BUF-1:0]      seq_rd_req,
   input  logic                    busy,
   input  logic [npu_pkg::ID_W-1:0] tgt,
   input  logic                    wr_fire,
   output logic [NUM_BUF-1:0]      read_en,
   output logic [NUM_BUF-1:0]      write_en
);
   import npu_pkg::*;

   logic [NUM_BUF-1:0] tgt_sel;
   logic [NUM_BUF-1:0] rd_mask;

   always_comb begin
      tgt_sel = '0;
      for (int i = 0; i < NUM_BUF; i++) begin
         tgt_sel[i] = (tgt == ID_W'(i));
      end
   end

   assign rd_mask  = busy ? tgt_sel : '0;
   assign read_en  = seq_rd_req & ~rd_mask;
   assign write_en = wr_fire ? tgt_sel : '0;

endmodule

// File: rtl/npu_cfg_loader.sv
// Config FIFO sequencer: decodes header/data/commit words
// and streams payloads into the selected circular buffer.
module npu_cfg_loader #(
   parameter int NUM_BUF = npu_pkg::NUM_BUF,
   parameter int DATA_W  = npu_pkg::DATA_W,
   parameter int CNT_W   = npu_pkg::CNT_W
) (
   input  logic                      CLK,
   input  logic                      npu_rst,
   input  logic [npu_pkg::FIFO_W-1:0] cfg_fifo_dout,
   input  logic                      cfg_fifo_empty,
   output logic                      cfg_fifo_rd_en,
   input  logic [NUM_BUF-1:0]        seq_rd_req,
   output logic [NUM_BUF-1:0]        cbuf_read_en,
   output logic [NUM_BUF-1:0]        cbuf_write_en,
   output logic [DATA_W-1:0]         cbuf_wdata,
   output logic [NUM_BUF-1:0]        cbuf_clear,
   output logic                      cfg_busy,
   output logic                      cfg_done,
   output logic                      cfg_error
);
   import npu_pkg::*;

   localparam logic [ID_W:0] NB_LIM = (ID_W+1)'(NUM_BUF);

   logic [0:0]         state_q;
   logic               rd_vld;
   logic [ID_W-1:0]    tgt_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W:0]     issued_q;
   logic [CNT_W:0]     written_q;
   logic               err_q;
   logic               done_q;
   logic [NUM_BUF-1:0] clear_q;
   logic [DATA_W-1:0]  wdata_q;

   cfg_word_t          w;
   logic               unused_bits;
   logic [DATA_W-1:0]  payload;
   logic [CNT_W-1:0]   hdr_cnt;
   logic               is_hdr;
   logic               is_data;
   logic               is_commit;
   logic               hdr_ok;
   logic               hdr_bad;
   logic               busy;
   logic               rd_en_raw;
   logic               wr_fire;
   logic               last_wr;
   logic [NUM_BUF-1:0] req_g;
   logic [NUM_BUF-1:0] wen_raw;

   assign w           = cfg_word_t'(cfg_fifo_dout);
   assign unused_bits = ^w.body;
   assign payload     = w.body[DATA_W-1:0];
   assign hdr_cnt     = w.body[CNT_W-1:0];

   assign is_hdr    = rd_vld && (w.op == OP_HDR);
   assign is_data   = rd_vld && (w.op == OP_DATA);
   assign is_commit = rd_vld && (w.op == OP_COMMIT);

   assign hdr_ok  = is_hdr && ({1'b0, w.id} < NB_LIM)
                 && (hdr_cnt != '0);
   assign hdr_bad = is_hdr && !hdr_ok;

   assign busy = (state_q == ST_LOAD);

   // One outstanding read while idle so a header never over-reads.
   always_comb begin
      rd_en_raw = 1'b0;
      if (!cfg_fifo_empty) begin
         if (busy) rd_en_raw = (issued_q < {1'b0, cnt_q});
         else      rd_en_raw = !rd_vld;
      end
   end

   assign wr_fire = busy && is_data;
   assign last_wr = wr_fire
                 && (written_q == ({1'b0, cnt_q} - 1'b1));

   always_ff @(posedge CLK) begin
      if (!npu_rst) begin
         state_q   <= ST_IDLE;
         rd_vld    <= 1'b0;
         tgt_q     <= '0;
         cnt_q     <= '0;
         issued_q  <= '0;
         written_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         clear_q   <= '0;
         wdata_q   <= '0;
      end else begin
         rd_vld  <= rd_en_raw;
         clear_q <= '0;
         done_q  <= 1'b0;
         if (wr_fire) wdata_q <= payload;
         if (busy) begin
            if (rd_en_raw) issued_q <= issued_q + 1'b1;
            if (wr_fire) begin
               written_q <= written_q + 1'b1;
               if (last_wr) state_q <= ST_IDLE;
            end else if (rd_vld) begin
               err_q   <= 1'b1;
               state_q <= ST_IDLE;
            end
         end else begin
            unique case (1'b1)
               hdr_ok: begin
                  tgt_q     <= w.id;
                  cnt_q     <= hdr_cnt;
                  issued_q  <= '0;
                  written_q <= '0;
                  clear_q   <= NUM_BUF'(1) << w.id;
                  state_q   <= ST_LOAD;
               end
               hdr_bad, is_data: err_q  <= 1'b1;
               is_commit:        done_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign req_g = seq_rd_req & {NUM_BUF{npu_rst}};

   npu_cbuf_port_arb #(
      .NUM_BUF (NUM_BUF)
   ) u_arb (
      .seq_rd_req (req_g),
      .busy       (busy),
      .tgt        (tgt_q),
      .wr_fire    (wr_fire),
      .read_en    (cbuf_read_en),
      .write_en   (wen_raw)
   );

   // Outputs read as zero for as long as reset is held.
   assign cbuf_write_en  = wen_raw & {NUM_BUF{npu_rst}};
   assign cfg_fifo_rd_en = npu_rst && rd_en_raw;
   assign cbuf_wdata     = !npu_rst ? '0
                         : (wr_fire ? payload : wdata_q);
   assign cbuf_clear     = clear_q & {NUM_BUF{npu_rst}};
   assign cfg_busy       = npu_rst && busy;
   assign cfg_done       = npu_rst && done_q;
   assign cfg_error      = npu_rst && err_q;

endmodule

// File: tb/tb_npu_cfg_loader.sv
// Randomized and directed bench for npu_cfg_loader with a
// word-level reference model and per-cycle output comparison.
module tb_npu_cfg_loader;

   logic        CLK = 1'b0;
   logic        npu_rst;
   logic [25:0] cfg_fifo_dout;
   logic        cfg_fifo_empty;
   logic        cfg_fifo_rd_en;
   logic [8:0]  seq_rd_req;
   logic [8:0]  cbuf_read_en;
   logic [8:0]  cbuf_write_en;
   logic [15:0] cbuf_wdata;
   logic [8:0]  cbuf_clear;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_error;

   always #5 CLK = ~CLK;

   npu_cfg_loader dut (
      .CLK            (CLK),
      .npu_rst        (npu_rst),
      .cfg_fifo_dout  (cfg_fifo_dout),
      .cfg_fifo_empty (cfg_fifo_empty),
      .cfg_fifo_rd_en (cfg_fifo_rd_en),
      .seq_rd_req     (seq_rd_req),
      .cbuf_read_en   (cbuf_read_en),
      .cbuf_write_en  (cbuf_write_en),
      .cbuf_wdata     (cbuf_wdata),
      .cbuf_clear     (cbuf_clear),
      .cfg_busy       (cfg_busy),
      .cfg_done       (cfg_done),
      .cfg_error      (cfg_error)
   );

   logic [25:0] fq[$];
   bit          stall;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;

   // reference model: remaining reads/writes of the active load
   bit          m_load, m_vld, m_err, m_done;
   int          m_tgt, m_iss, m_wr, m_clr;
   logic [15:0] m_wd;

   int          wr_buf[$];
   int          wr_cyc[$];
   logic [15:0] wr_dat[$];
   int          done_cyc[$];
   int          first_rd, clr_cyc, busy_fall;
   logic [8:0]  clr_or, busy_rd, idle_rd;
   bit          prev_busy;

   function automatic logic [25:0] mk_hdr(int id, int cnt);
      return {2'b01, 4'(id), 10'd0, 10'(cnt)};
   endfunction

   function automatic logic [25:0] mk_data(int d);
      return {2'b10, 8'h00, 16'(d)};
   endfunction

   localparam logic [25:0] W_COMMIT = {2'b11, 24'h0};
   localparam logic [25:0] W_NOP    = 26'h0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_load = 0; m_vld = 0; m_err = 0; m_done = 0;
      m_tgt = 0; m_iss = 0; m_wr = 0; m_clr = -1;
      m_wd = '0;
   endtask

   task automatic clear_log();
      wr_buf.delete(); wr_cyc.delete(); wr_dat.delete();
      done_cyc.delete();
      first_rd = -1; clr_cyc = -1; busy_fall = -1;
      clr_or = '0; busy_rd = '0; idle_rd = '0;
   endtask

   task automatic step();
      logic        e_rd, e_busy, e_done, e_err, wr, dut_rd;
      logic [8:0]  e_rden, e_wen, e_clr, tmask;
      logic [15:0] e_wd;
      logic [1:0]  op;
      int          id, cnt, n_clr;
      bit          n_done;
      @(negedge CLK);
      cfg_fifo_empty = (fq.size() == 0) || stall;
      #1;
      op  = cfg_fifo_dout[25:24];
      id  = int'(cfg_fifo_dout[23:20]);
      cnt = int'(cfg_fifo_dout[9:0]);
      e_rd = 0; e_busy = 0; e_done = 0; e_err = 0; wr = 0;
      e_rden = '0; e_wen = '0; e_clr = '0; e_wd = '0;
      if (npu_rst) begin
         e_busy = m_load;
         e_err  = m_err;
         e_done = m_done;
         e_clr  = (m_clr >= 0) ? 9'(1) << m_clr : 9'h0;
         if (!cfg_fifo_empty)
            e_rd = m_load ? (m_iss > 0) : !m_vld;
         tmask  = m_load ? 9'(1) << m_tgt : 9'h0;
         e_rden = seq_rd_req & ~tmask;
         wr     = m_load && m_vld && (op == 2'b10);
         e_wen  = wr ? 9'(1) << m_tgt : 9'h0;
         e_wd   = wr ? cfg_fifo_dout[15:0] : m_wd;
      end
      chk("rd_en", cfg_fifo_rd_en, e_rd);
      chk("read_en", cbuf_read_en, e_rden);
      chk("write_en", cbuf_write_en, e_wen);
      chk("wdata", cbuf_wdata, e_wd);
      chk("clear", cbuf_clear, e_clr);
      chk("busy", cfg_busy, e_busy);
      chk("done", cfg_done, e_done);
      chk("error", cfg_error, e_err);
      chk("port_overlap", cbuf_read_en & cbuf_write_en, 0);
      // observation log for the directed literal checks
      if (first_rd < 0 && cfg_fifo_rd_en) first_rd = cyc;
      for (int i = 0; i < 9; i++) begin
         if (cbuf_write_en[i]) begin
            wr_buf.push_back(i);
            wr_cyc.push_back(cyc);
            wr_dat.push_back(cbuf_wdata);
         end
      end
      if (cbuf_clear != 0) clr_cyc = cyc;
      clr_or = clr_or | cbuf_clear;
      if (cfg_done) done_cyc.push_back(cyc);
      if (prev_busy && !cfg_busy) busy_fall = cyc;
      if (cfg_busy) busy_rd = cbuf_read_en;
      else          idle_rd = cbuf_read_en;
      prev_busy = cfg_busy;
      dut_rd = cfg_fifo_rd_en;
      // model next state
      if (!npu_rst) begin
         model_reset();
      end else begin
         n_clr = -1; n_done = 0;
         if (m_load) begin
            if (e_rd) m_iss--;
            if (m_vld) begin
               if (op == 2'b10) begin
                  m_wr--;
                  if (m_wr == 0) m_load = 0;
               end else begin
                  m_err = 1; m_load = 0;
               end
            end
         end else if (m_vld) begin
            if (op == 2'b01) begin
               if (id < 9 && cnt != 0) begin
                  m_load = 1; m_tgt = id;
                  m_iss = cnt; m_wr = cnt; n_clr = id;
               end else m_err = 1;
            end else if (op == 2'b10) m_err = 1;
            else if (op == 2'b11) n_done = 1;
         end
         m_vld = e_rd; m_wd = e_wd;
         m_clr = n_clr; m_done = n_done;
      end
      @(posedge CLK);
      #1;
      if (dut_rd && fq.size() > 0) cfg_fifo_dout = fq.pop_front();
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      npu_rst = 0; stall = 0; seq_rd_req = '0;
      fq.delete();
      run(2);
      npu_rst = 1;
   endtask

   initial begin
      npu_rst = 0; stall = 0; seq_rd_req = '0;
      cfg_fifo_dout = '0; cfg_fifo_empty = 1;
      prev_busy = 0;
      model_reset(); clear_log();
      run(3);
      chk("reset_error", cfg_error, 0);
      chk("reset_busy", cfg_busy, 0);
      npu_rst = 1;
      run(2);

      // basic load, FIFO pre-filled
      clear_log();
      fq.push_back(mk_hdr(3, 4));
      for (int k = 1; k <= 4; k++) fq.push_back(mk_data(k * 'h11));
      run(10);
      chk("s1_clear_lat", clr_cyc - first_rd, 2);
      chk("s1_clear_buf", clr_or, 9'h008);
      chk("s1_nwr", wr_buf.size(), 4);
      for (int k = 0; k < 4 && k < wr_buf.size(); k++) begin
         chk("s1_wbuf", wr_buf[k], 3);
         chk("s1_wdat", wr_dat[k], (k + 1) * 'h11);
         chk("s1_wcyc", wr_cyc[k] - first_rd, 3 + k);
      end
      chk("s1_busy_fall", busy_fall - first_rd, 7);

      // same load with all read requests held
      clear_log();
      seq_rd_req = 9'h1FF;
      fq.push_back(mk_hdr(3, 4));
      for (int k = 1; k <= 4; k++) fq.push_back(mk_data(k * 'h11));
      run(10);
      chk("s2_rd_busy", busy_rd, 9'h1F7);
      chk("s2_rd_idle", idle_rd, 9'h1FF);
      seq_rd_req = '0;

      // small buffer with an empty gap between data words
      clear_log();
      fq.push_back(mk_hdr(8, 2));
      fq.push_back(mk_data('hA1));
      run(11);
      chk("s3_gap_busy", cfg_busy, 1);
      chk("s3_gap_nwr", wr_buf.size(), 1);
      fq.push_back(mk_data('hB2));
      run(5);
      chk("s3_nwr", wr_buf.size(), 2);
      if (wr_buf.size() == 2) begin
         chk("s3_wbuf", wr_buf[1], 8);
         chk("s3_wdat", wr_dat[1], 16'hB2);
      end
      chk("s3_idle", cfg_busy, 0);

      // bad id, stray data, then a good load
      do_reset(); clear_log();
      fq.push_back(mk_hdr(9, 1));
      fq.push_back(mk_data('h55));
      fq.push_back(mk_hdr(0, 1));
      fq.push_back(mk_data('h66));
      run(14);
      chk("s4_error", cfg_error, 1);
      chk("s4_clear", clr_or, 9'h001);
      chk("s4_nwr", wr_buf.size(), 1);
      if (wr_buf.size() == 1) begin
         chk("s4_wbuf", wr_buf[0], 0);
         chk("s4_wdat", wr_dat[0], 16'h66);
      end

      // commit arriving inside a load
      do_reset(); clear_log();
      fq.push_back(mk_hdr(1, 3));
      fq.push_back(mk_data('h77));
      fq.push_back(W_COMMIT);
      fq.push_back(W_NOP);
      run(10);
      chk("s5_error", cfg_error, 1);
      chk("s5_nwr", wr_buf.size(), 1);
      chk("s5_ndone", done_cyc.size(), 0);
      chk("s5_idle", cfg_busy, 0);

      // standalone commit
      clear_log();
      fq.push_back(W_COMMIT);
      run(5);
      chk("commit_n", done_cyc.size(), 1);
      if (done_cyc.size() == 1)
         chk("commit_lat", done_cyc[0] - first_rd, 2);

      // reset in the middle of a load
      do_reset(); clear_log();
      fq.push_back(mk_hdr(2, 4));
      for (int k = 0; k < 4; k++) fq.push_back(mk_data('hC0 + k));
      run(2);
      npu_rst = 0;
      run(1);
      chk("s6_busy_rst", cfg_busy, 0);
      fq.delete();
      run(1);
      npu_rst = 1;
      clear_log();
      fq.push_back(mk_hdr(2, 1));
      fq.push_back(mk_data('h99));
      run(8);
      chk("s6_nwr", wr_buf.size(), 1);
      if (wr_buf.size() == 1) begin
         chk("s6_wbuf", wr_buf[0], 2);
         chk("s6_wdat", wr_dat[0], 16'h99);
      end

      // largest count the header can carry
      do_reset(); clear_log();
      fq.push_back(mk_hdr(5, 1023));
      for (int k = 0; k < 1023; k++) fq.push_back(mk_data(k));
      run(1035);
      chk("max_nwr", wr_buf.size(), 1023);
      chk("max_busy_fall", busy_fall - first_rd, 1026);
      if (wr_buf.size() == 1023)
         chk("max_last", wr_dat[1022], 16'd1022);

      // random traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         if (fq.size() < 8 && $urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 9);
            if (r < 3)
               fq.push_back(mk_hdr($urandom_range(0, 10),
                                   $urandom_range(0, 5)));
            else if (r < 8) fq.push_back(mk_data($urandom));
            else if (r == 8) fq.push_back(W_COMMIT);
            else fq.push_back(W_NOP);
         end
         stall = ($urandom_range(0, 3) == 0);
         seq_rd_req = 9'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            npu_rst = 0;
            fq.delete();
         end else begin
            npu_rst = 1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
